sequential_borrow_subtractor_32: RTL and testbench



---
 rtl/sequential_borrow_subtractor_32.sv | 169 ++++++++++++++++
 tb/tb_sequential_borrow_subtractor_32.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sequential_borrow_subtractor_32.sv
// Multi-cycle subtractor: diff = A - B - Bin, one SLICE-bit slice per clock with a registered borrow.
// Optional signed-overflow flag V is built only when SUB_OVERFLOW_FLAG_EN is defined.
module sequential_borrow_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             zero,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              borrow_r;
  logic [IDXW-1:0]   idx_r;
  logic [WIDTH-1:0]  diff_r;
  logic              bout_r;
  logic              zero_r;
  logic              busy_r;
  logic              done_r;
  logic              accept_s;
  logic              last_s;
  logic              busy_s;
  logic              done_s;
  int                off_s;
  logic [SLICE:0]    slice_s;
  logic [WIDTH-1:0]  diff_next_s;

  // Slice subtract; bit SLICE of the result is the borrow out.
  function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             bi);
    sub_slice = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bi};
  endfunction

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s   = (idx_r == IDXW'(N - 1));

  // Current slice result and the diff word with that slice merged in.
  always_comb begin
    off_s       = int'(idx_r) * SLICE;
    slice_s     = sub_slice(a_r[off_s +: SLICE], b_r[off_s +: SLICE], borrow_r);
    diff_next_s = diff_r;
    diff_next_s[off_s +: SLICE] = slice_s[SLICE-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start during RUN is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_s = ST_DONE;
        else        state_s = ST_RUN;
      end
      ST_DONE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs derived from the upcoming state, then registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_RUN:  busy_s = 1'b1;
      ST_DONE: done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, slice ripple and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      idx_r    <= {IDXW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if (accept_s) begin
        a_r      <= A;
        b_r      <= B;
        borrow_r <= Bin;
        idx_r    <= {IDXW{1'b0}};
      end else if (state_r == ST_RUN) begin
        diff_r   <= diff_next_s;
        borrow_r <= slice_s[SLICE];
        if (last_s) begin
          idx_r  <= {IDXW{1'b0}};
          bout_r <= slice_s[SLICE];
          zero_r <= (diff_next_s == {WIDTH{1'b0}});
        end else begin
          idx_r  <= idx_r + IDXW'(1);
        end
      end
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  logic v_r;

  // Signed overflow: operand signs differ and the result sign departs from A.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if ((state_r == ST_RUN) && last_s && !accept_s) begin
      v_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end else begin
      v_r <= v_r;
    end
  end

  assign V = v_r;
`else
  assign V = 1'b0;
`endif

  assign diff = diff_r;
  assign Bout = bout_r;
  assign zero = zero_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_sequential_borrow_subtractor_32.sv
// Directed, table-driven bench for sequential_borrow_subtractor_32 plus handshake/reset sequences.
// Expected V follows SUB_OVERFLOW_FLAG_EN.
module tb_sequential_borrow_subtractor_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic [31:0] diff;
  logic        Bout;
  logic        zero;
  logic        V;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] exp_diff;
    logic        exp_bout;
    logic        exp_zero;
    logic        exp_v;   // value when the overflow flag is built
  } vec_t;

  vec_t vecs[10];

  sequential_borrow_subtractor_32 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .diff (diff),
    .Bout (Bout),
    .zero (zero),
    .V    (V),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic exp_v_of(input logic v);
`ifdef SUB_OVERFLOW_FLAG_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Counts negedges until done (bounded), checking busy/done exclusivity each cycle.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (!done) check("busy_while_run", {31'd0, busy}, 32'd1);
    end while (!done && n < 20);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, n, 32'd5);
    check({tag, "_diff"}, diff, v.exp_diff);
    check({tag, "_bout"}, {31'd0, Bout}, {31'd0, v.exp_bout});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
    check({tag, "_v"}, {31'd0, V}, {31'd0, exp_v_of(v.exp_v)});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_diff"}, diff, v.exp_diff);
  endtask

  initial begin
    int   n;
    int   m;
    int   seen;
    vec_t v;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_diff", diff, 32'd0);
    check("rst_flags", {26'd0, Bout, zero, V, busy, done, 1'b0}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed during RUN with new operands must be ignored.
    @(negedge clk);
    A = 32'd10; B = 32'd4; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    A = 32'd100; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 32'hFFFF_FFFF;
    wait_done(n);
    check("ignore_latency", n, 32'd3);
    check("ignore_diff", diff, 32'd6);
    check("ignore_bout", {31'd0, Bout}, 32'd0);
    @(negedge clk);
    check("ignore_no_second", {30'd0, busy, done}, 32'd0);

    // start held through DONE: second operation accepted directly from DONE.
    @(negedge clk);
    A = 32'd20; B = 32'd7; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 A = 32'd50; B = 32'd8;
    wait_done(n);
    check("b2b_first_latency", n, 32'd5);
    check("b2b_first_diff", diff, 32'd13);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(m);
    check("b2b_second_spacing", m, 32'd5);
    check("b2b_second_diff", diff, 32'd42);
    @(negedge clk);

    // Reset asserted in cycle 2 of RUN aborts the operation.
    A = 32'd9; B = 32'd2; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_diff", diff, 32'd0);
    check("midrst_flags", {27'd0, Bout, zero, V, busy, done}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst_no_done", seen, 32'd0);
    v = '{32'd9, 32'd2, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0};
    run_vec(v, "after_rst");

    // start and rst on the same edge: reset wins.
    @(negedge clk);
    A = 32'd1; B = 32'd1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_beats_start", {30'd0, busy, done}, 32'd0);
    check("rst_beats_start_diff", diff, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
